// File: rtl/a5_burst_sequencer_pkg.sv
// Shared types and A5/1 constants for the burst sequencer slice.
package a5_burst_sequencer_pkg;

    localparam int KEY_W         = 64;   // session key width
    localparam int FRAME_W       = 22;   // frame number width
    localparam int A5_BURST_BITS = 114;  // keystream bits per burst, two bursts per frame
    localparam int A5_WORD_W     = 32;   // default output word width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_INIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_NEXT   = 3'd5
    } state_e;

endpackage

// File: rtl/a5_burst_sequencer_if.sv
// Output word stream of the burst sequencer.
// Handshake: a word transfers on every rising edge where out_valid=1 and
// out_ready=1; once out_valid is raised, out_data/out_nbits/out_last/out_burst
// hold steady until that transfer, and out_valid never waits on out_ready.
interface a5_burst_sequencer_if
    import a5_burst_sequencer_pkg::*;
#(
    parameter int WORD_W = A5_WORD_W
);
    localparam int NB_W = $clog2(WORD_W) + 1;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [NB_W-1:0]   out_nbits;
    logic              out_last;
    logic              out_burst;

    modport master (
        output out_valid, out_data, out_nbits, out_last, out_burst,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_nbits, out_last, out_burst,
        output out_ready
    );

endinterface

// File: rtl/a5_word_packer.sv
// Packs keystream bits LSB-first into words and owns the output register.
// A completed word parks in the assembly register (full=1) until the output
// register is free, so the upstream FSM must not offer bits while full=1.
module a5_word_packer
    import a5_burst_sequencer_pkg::*;
#(
    parameter int WORD_W = A5_WORD_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,      // abort: drop assembly and output register
    input  logic bit_en,     // consume bit_in this edge
    input  logic bit_in,
    input  logic bit_end,    // bit_in is the last bit of a burst
    input  logic bit_burst,  // burst id of bit_in
    output logic full,       // assembly word complete, waiting for output register
    output logic drained,    // nothing left after this edge
    a5_burst_sequencer_if.master out_if
);
    localparam int NB_W = $clog2(WORD_W) + 1;

    logic [WORD_W-1:0] asm_q, asm_d;
    logic [NB_W-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              last_q, last_d;
    logic              burst_q, burst_d;
    logic              ov_q, ov_d;
    logic [WORD_W-1:0] od_q, od_d;
    logic [NB_W-1:0]   onb_q, onb_d;
    logic              ol_q, ol_d;
    logic              ob_q, ob_d;

    // Next-state for the assembly word and the output register.
    always_comb begin
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        last_d  = last_q;
        burst_d = burst_q;
        ov_d    = ov_q;
        od_d    = od_q;
        onb_d   = onb_q;
        ol_d    = ol_q;
        ob_d    = ob_q;
        if (pend_q && (!ov_q || out_if.out_ready)) begin
            ov_d    = 1'b1;
            od_d    = asm_q;
            onb_d   = cnt_q;
            ol_d    = last_q;
            ob_d    = burst_q;
            asm_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            last_d  = 1'b0;
            burst_d = 1'b0;
        end else if (ov_q && out_if.out_ready) begin
            ov_d = 1'b0;
        end
        // bit_en is only offered while pend_q=0, so it never meets the move above
        if (bit_en) begin
            asm_d[cnt_q[NB_W-2:0]] = bit_in;
            cnt_d   = cnt_q + 1'b1;
            burst_d = bit_burst;
            if (bit_end || cnt_q == NB_W'(WORD_W - 1)) begin
                pend_d = 1'b1;
                last_d = bit_end;
            end
        end
        if (clear) begin
            asm_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            last_d  = 1'b0;
            burst_d = 1'b0;
            ov_d    = 1'b0;
            od_d    = '0;
            onb_d   = '0;
            ol_d    = 1'b0;
            ob_d    = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            burst_q <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            onb_q   <= '0;
            ol_q    <= 1'b0;
            ob_q    <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            onb_q   <= onb_d;
            ol_q    <= ol_d;
            ob_q    <= ob_d;
        end
    end

    assign full             = pend_q;
    assign drained          = !pend_q && (!ov_q || out_if.out_ready);
    assign out_if.out_valid = ov_q;
    assign out_if.out_data  = od_q;
    assign out_if.out_nbits = onb_q;
    assign out_if.out_last  = ol_q;
    assign out_if.out_burst = ob_q;

endmodule

// File: rtl/a5_burst_sequencer.sv
// Drives an external A5/1 keystream generator frame by frame and streams the
// 2 x BURST_BITS keystream bits of every frame out as packed words.
module a5_burst_sequencer
    import a5_burst_sequencer_pkg::*;
#(
    parameter int WORD_W     = A5_WORD_W,
    parameter int BURST_BITS = A5_BURST_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_W-1:0]   key,
    input  logic [FRAME_W-1:0] frame,
    input  logic [7:0]         num_frames,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               gen_load,
    output logic               gen_stall,
    output logic [KEY_W-1:0]   gen_key,
    output logic [FRAME_W-1:0] gen_frame,
    input  logic               gen_q,
    input  logic               gen_valid,
    a5_burst_sequencer_if.master out_if,
    output logic [2:0]         dbg_state
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_INIT   = ST_INIT;
    localparam logic [2:0] S_STREAM = ST_STREAM;
    localparam logic [2:0] S_FLUSH  = ST_FLUSH;
    localparam logic [2:0] S_NEXT   = ST_NEXT;
    localparam int BC_W = $clog2(2 * BURST_BITS);

    logic [2:0]         state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [7:0]         left_q, left_d;      // frames still to run after the current one
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic               done_q, done_d;
    logic               pk_full, pk_drained, consume, bit_end, bit_burst;

    assign gen_stall = !(state_q == S_STREAM && !pk_full);
    assign consume   = (state_q == S_STREAM) && gen_valid && !gen_stall;
    assign bit_end   = (bit_cnt_q == BC_W'(BURST_BITS - 1)) ||
                       (bit_cnt_q == BC_W'(2 * BURST_BITS - 1));
    assign bit_burst = (bit_cnt_q >= BC_W'(BURST_BITS));

    // Frame sequencing FSM and its counters; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        frame_d   = frame_q;
        left_d    = left_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d     = key;
                    frame_d   = frame;
                    left_d    = (num_frames == 8'd0) ? 8'd0 : num_frames - 8'd1;
                    bit_cnt_d = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: state_d = S_INIT;
            S_INIT: begin
                if (gen_valid) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (consume) begin
                    if (bit_cnt_q == BC_W'(2 * BURST_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_FLUSH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (pk_drained) begin
                    if (left_q != 8'd0) begin
                        state_d = S_NEXT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_NEXT: begin
                frame_d = frame_q + 1'b1;
                left_d  = left_q - 8'd1;
                state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    // FSM and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            frame_q   <= '0;
            left_q    <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            frame_q   <= frame_d;
            left_q    <= left_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign gen_load  = (state_q == S_LOAD);
    assign gen_key   = key_q;
    assign gen_frame = frame_q;
    assign dbg_state = state_q;

    a5_word_packer #(.WORD_W(WORD_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort),
        .bit_en    (consume),
        .bit_in    (gen_q),
        .bit_end   (bit_end),
        .bit_burst (bit_burst),
        .full      (pk_full),
        .drained   (pk_drained),
        .out_if    (out_if)
    );

endmodule

// File: tb/tb_a5_burst_sequencer.sv
// Directed bench for a5_burst_sequencer with a behavioural A5/1 generator.
module tb_a5_burst_sequencer;
    import a5_burst_sequencer_pkg::*;

    localparam int W        = 40;   // {burst, last, nbits[5:0], data[31:0]}
    localparam int INIT_CYC = 186;
    localparam logic [63:0] K1 = 64'h1223456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] K3 = 64'hDEADBEEF01234567;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [63:0] key, gen_key;
    logic [21:0] frame, gen_frame;
    logic [7:0]  num_frames;
    logic        busy, done, gen_load, gen_stall;
    logic        gen_q = 1'b0, gen_valid = 1'b0;
    logic [2:0]  dbg_state;
    logic        rand_ready = 1'b0;

    a5_burst_sequencer_if #(.WORD_W(32)) out_if ();

    a5_burst_sequencer #(.WORD_W(32), .BURST_BITS(114)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .frame      (frame),
        .num_frames (num_frames),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .gen_load   (gen_load),
        .gen_stall  (gen_stall),
        .gen_key    (gen_key),
        .gen_frame  (gen_frame),
        .gen_q      (gen_q),
        .gen_valid  (gen_valid),
        .out_if     (out_if),
        .dbg_state  (dbg_state)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [21:0]  frame_log[$];
    int n_checks = 0, n_errors = 0;
    int words_acc = 0, last_cnt = 0, done_cnt = 0, load_cnt = 0, bits_consumed = 0;
    int words_at_done = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden A5/1: 64 key clocks, 22 frame clocks, 100 mixing clocks, 228 output bits.
    function automatic logic [227:0] a5_ks(input logic [63:0] k, input logic [21:0] f);
        logic [18:0]  r1;
        logic [21:0]  r2;
        logic [22:0]  r3;
        logic [227:0] ks;
        logic         m;
        r1 = '0; r2 = '0; r3 = '0; ks = '0;
        for (int i = 0; i < 64; i++) begin
            r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ k[i]};
            r2 = {r2[20:0], r2[21] ^ r2[20] ^ k[i]};
            r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ k[i]};
        end
        for (int i = 0; i < 22; i++) begin
            r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ f[i]};
            r2 = {r2[20:0], r2[21] ^ r2[20] ^ f[i]};
            r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ f[i]};
        end
        for (int i = 0; i < 328; i++) begin
            m = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
            if (r1[8] == m)  r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13]};
            if (r2[10] == m) r2 = {r2[20:0], r2[21] ^ r2[20]};
            if (r3[10] == m) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7]};
            if (i >= 100) ks[i-100] = r1[18] ^ r2[21] ^ r3[22];
        end
        return ks;
    endfunction

    // Expected words of one frame: per burst nbits 32,32,32,18, last on the 18-bit word.
    task automatic push_frame(input logic [63:0] k, input logic [21:0] f);
        logic [227:0] ks;
        logic [31:0]  d;
        int           nb;
        ks = a5_ks(k, f);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 4; w++) begin
                nb = (w == 3) ? 18 : 32;
                d  = '0;
                for (int i = 0; i < nb; i++) d[i] = ks[b*114 + w*32 + i];
                exp_q.push_back({1'(b), (w == 3), 6'(nb), d});
            end
        end
    endtask

    // ---------------- behavioural keystream generator ----------------
    logic [227:0] ks_cur = '0;
    int           init_left = 0, idx = 0;
    logic         adv_s, ld_s;
    logic [63:0]  k_s;
    logic [21:0]  f_s;

    // Sample the DUT's request at the edge, answer just after it.
    always @(posedge clk) begin
        adv_s = gen_valid && !gen_stall;
        ld_s  = gen_load;
        k_s   = gen_key;
        f_s   = gen_frame;
        #1;
        if (ld_s) begin
            ks_cur    = a5_ks(k_s, f_s);
            idx       = 0;
            init_left = INIT_CYC;
            gen_valid = 1'b0;
            load_cnt++;
            frame_log.push_back(f_s);
        end else if (init_left != 0) begin
            init_left--;
            if (init_left == 0) gen_valid = 1'b1;
        end else if (adv_s) begin
            idx++;
            bits_consumed++;
        end
        gen_q = (idx < 228) ? ks_cur[idx] : 1'b0;
    end

    // Sink ready: always 1, or a fair coin per cycle.
    always @(negedge clk) begin
        out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: compare accepted words, check hold under backpressure, count done.
    logic [W-1:0] held = '0;
    logic         hold_pend = 1'b0;
    always @(posedge clk) begin
        logic [W-1:0] cur;
        cur = {out_if.out_burst, out_if.out_last, out_if.out_nbits, out_if.out_data};
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && out_if.out_valid) check("hold_stable", cur, held);
            hold_pend = out_if.out_valid && !out_if.out_ready;
            held      = cur;
            if (out_if.out_valid && out_if.out_ready) begin
                words_acc++;
                if (out_if.out_last) last_cnt++;
                if (exp_q.size() == 0) check("word_expected", 64'(exp_q.size() != 0), 1);
                else check("word", cur, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                words_at_done = words_acc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [63:0] k, input logic [21:0] f, input logic [7:0] n);
        @(negedge clk);
        key = k; frame = f; num_frames = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    task automatic wait_bits(input string tag, input int b0, input int n, input int budget);
        int c = 0;
        while (bits_consumed - b0 < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(bits_consumed - b0 >= n), 1);
    endtask

    // ---------------- directed sequence ----------------
    int w0, l0, d0, g0, b0, f0, c;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        key = '0; frame = '0; num_frames = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_if.out_valid, 0);
        check("rst_gen_load", gen_load, 0);
        check("rst_gen_stall", gen_stall, 1);
        check("rst_data", out_if.out_data, 0);
        check("rst_nbits", out_if.out_nbits, 0);
        check("rst_last", out_if.out_last, 0);
        check("rst_burst", out_if.out_burst, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // one frame, sink always ready
        w0 = words_acc; l0 = last_cnt; d0 = done_cnt; g0 = load_cnt; b0 = bits_consumed;
        push_frame(K1, 22'h134);
        do_start(K1, 22'h134, 8'd1);
        wait_done("t1_done", d0, 3000);
        repeat (5) @(negedge clk);
        check("t1_words", words_acc - w0, 8);
        check("t1_last_cnt", last_cnt - l0, 2);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_loads", load_cnt - g0, 1);
        check("t1_bits", bits_consumed - b0, 228);
        check("t1_single_done", done_cnt - d0, 1);
        check("t1_busy", busy, 0);

        // same frame under random backpressure
        rand_ready = 1'b1;
        w0 = words_acc; d0 = done_cnt; b0 = bits_consumed;
        push_frame(K1, 22'h134);
        do_start(K1, 22'h134, 8'd1);
        wait_done("t2_done", d0, 5000);
        repeat (5) @(negedge clk);
        rand_ready = 1'b0;
        check("t2_words", words_acc - w0, 8);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_bits", bits_consumed - b0, 228);

        // three frames across the frame-number wrap
        w0 = words_acc; d0 = done_cnt; g0 = load_cnt; f0 = frame_log.size();
        push_frame(K1, 22'h3FFFFF);
        push_frame(K1, 22'h000000);
        push_frame(K1, 22'h000001);
        do_start(K1, 22'h3FFFFF, 8'd3);
        wait_done("t3_done", d0, 8000);
        repeat (5) @(negedge clk);
        check("t3_loads", load_cnt - g0, 3);
        check("t3_frame0", frame_log[f0], 22'h3FFFFF);
        check("t3_frame1", frame_log[f0+1], 22'h000000);
        check("t3_frame2", frame_log[f0+2], 22'h000001);
        check("t3_words_at_done", words_at_done - w0, 24);
        check("t3_single_done", done_cnt - d0, 1);
        check("t3_queue_empty", exp_q.size(), 0);

        // abort on the 50th consumed bit
        w0 = words_acc; d0 = done_cnt; b0 = bits_consumed;
        push_frame(K2, 22'h55);
        do_start(K2, 22'h55, 8'd1);
        c = 0;
        while (!(bits_consumed - b0 == 49 && gen_valid && !gen_stall) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("t4_reach_49", bits_consumed - b0, 49);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_state_idle", dbg_state, ST_IDLE);
        check("t4_busy", busy, 0);
        check("t4_valid", out_if.out_valid, 0);
        check("t4_bits", bits_consumed - b0, 50);
        check("t4_words_before", words_acc - w0, 1);
        exp_q.delete();
        repeat (30) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        w0 = words_acc; d0 = done_cnt;
        push_frame(K2, 22'h55);
        do_start(K2, 22'h55, 8'd1);
        wait_done("t4_restart_done", d0, 3000);
        repeat (5) @(negedge clk);
        check("t4_restart_words", words_acc - w0, 8);
        check("t4_queue_empty", exp_q.size(), 0);

        // start while busy is ignored
        w0 = words_acc; d0 = done_cnt; g0 = load_cnt; b0 = bits_consumed;
        push_frame(K3, 22'h2AAAA);
        do_start(K3, 22'h2AAAA, 8'd1);
        repeat (10) @(negedge clk);
        key = ~K3; frame = 22'h1; num_frames = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_key_init", gen_key, K3);
        check("t5_frame_init", gen_frame, 22'h2AAAA);
        wait_bits("t5_stream", b0, 10, 2000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_key_stream", gen_key, K3);
        wait_done("t5_done", d0, 3000);
        repeat (5) @(negedge clk);
        check("t5_loads", load_cnt - g0, 1);
        check("t5_words", words_acc - w0, 8);
        check("t5_queue_empty", exp_q.size(), 0);

        // reset in the middle of STREAM
        d0 = done_cnt; b0 = bits_consumed;
        push_frame(K1, 22'h134);
        do_start(K1, 22'h134, 8'd1);
        wait_bits("t6_stream", b0, 40, 2000);
        check("t6_in_stream", dbg_state, ST_STREAM);
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_valid", out_if.out_valid, 0);
        check("t6_gen_load", gen_load, 0);
        check("t6_gen_stall", gen_stall, 1);
        check("t6_data", out_if.out_data, 0);
        check("t6_nbits", out_if.out_nbits, 0);
        check("t6_last", out_if.out_last, 0);
        check("t6_burst", out_if.out_burst, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (300) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/a5_burst_sequencer.md
A5_BURST_SEQUENCER -- requirements
Module: a5_burst_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning output word width.
REQ-002 SHALL have parameter BURST_BITS, default 114, meaning keystream bits per burst; two bursts per frame.
REQ-003 SHALL have ports clk in 1 (sole clock) and reset in 1 (synchronous, active-high); no other clock or reset exists.
REQ-004 SHALL have ports start in 1 (request), key in 64 (session key), frame in 22 (first frame number), num_frames in 8 (frames to generate, 0 treated as 1), abort in 1 (cancel).
REQ-005 SHALL have ports busy out 1 (not IDLE) and done out 1 (one-cycle completion pulse).
REQ-006 SHALL have generator-side ports gen_load out 1, gen_stall out 1, gen_key out 64, gen_frame out 22, gen_q in 1 (keystream bit), gen_valid in 1 (keystream valid).
REQ-007 SHALL have output-stream ports out_valid out 1, out_ready in 1, out_data out WORD_W, out_nbits out $clog2(WORD_W)+1 (valid bits), out_last out 1 (final word of burst), out_burst out 1 (0 = A->B, 1 = B->A).

Function
REQ-008 SHALL implement states IDLE, LOAD, INIT, STREAM, FLUSH, NEXT.
REQ-009 IDLE: start=1 SHALL latch key, frame and num_frames, then go to LOAD; start in any other state SHALL be ignored.
REQ-010 LOAD SHALL assert gen_load for exactly one cycle with gen_key/gen_frame driven from the latched values, then go to INIT.
REQ-011 INIT SHALL wait for gen_valid=1, then go to STREAM; there is no timeout (nominal init is 186 cycles).
REQ-012 A keystream bit SHALL be consumed on each rising edge where state=STREAM, gen_valid=1 and gen_stall=0; no other edge consumes a bit.
REQ-013 gen_stall SHALL be 0 only in STREAM while the assembly word is not complete; it SHALL be 1 in all other states.
REQ-014 Bits SHALL pack LSB-first: the first bit of a word goes to out_data[0]; unused bits of a partial word SHALL be 0.
REQ-015 A word SHALL complete after WORD_W bits or at the last bit of a burst; with defaults a burst yields 3 full words plus 1 word of 18 bits with out_last=1.
REQ-016 A complete word SHALL move to the output register on the edge where out_valid=0 or out_ready=1; otherwise assembly holds and generation stalls.
REQ-017 out_data, out_nbits, out_last and out_burst SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 Bits 0..BURST_BITS-1 of a frame SHALL form burst 0 and the next BURST_BITS bits burst 1, with no discarded bits between them.
REQ-019 After the 2*BURST_BITS-th bit the FSM SHALL go to FLUSH and wait until the final word is accepted.
REQ-020 FLUSH SHALL go to NEXT when frames remain; otherwise it SHALL pulse done and return to IDLE.
REQ-021 NEXT SHALL increment the latched frame modulo 2^22 (0x3FFFFF wraps to 0), decrement the remaining count, then go to LOAD.
REQ-022 abort=1 in any state SHALL return the FSM to IDLE on the next edge, clear out_valid and the assembly word, and suppress done; abort has priority over start.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 reset SHALL put the FSM in IDLE and set busy, done, out_valid, gen_load, out_last and out_burst to 0, gen_stall to 1, and out_data, out_nbits and counters to 0.
REQ-025 reset mid-stream SHALL discard all pending words without a done pulse.

Structure
REQ-026 Shared package SHALL hold the state enum, the A5 constants (KEY_W=64, FRAME_W=22, BURST_BITS=114) and the default WORD_W.
REQ-027 One sub-module, a5_word_packer (bit assembly plus output register and handshake), SHALL be instantiated; the FSM and counters stay top-level.

Verification
REQ-028 Start with key=64'h1223456789ABCDEF, frame=22'h134, num_frames=1, out_ready=1 tied to a real generator -> 8 words with nbits 32,32,32,18 per burst, out_last on words 4 and 8, and the 228 bits match the golden software model.
REQ-029 Same as REQ-028 with out_ready toggling randomly (50%) -> identical bit sequence, no bit lost or duplicated, outputs held stable during backpressure.
REQ-030 frame=22'h3FFFFF, num_frames=3 -> gen_frame sequence 3FFFFF, 000000, 000001, three gen_load pulses, a single done after the 24th word.
REQ-031 abort asserted on the 50th consumed bit -> IDLE next cycle, out_valid=0, no done; a subsequent start produces the full correct stream.
REQ-032 start pulsed while busy -> ignored, latched key/frame unchanged; reset asserted in STREAM -> all outputs at reset values next cycle.
